console_edit_buffer: RTL and testbench
======================================

Name: console_edit_buffer

Overview:
- Parametrised program-text buffer and cursor controller for the brainfuck console. Successor to the fixed single-device console wrapper.
- Stores up to DEPTH symbols of SYM_W bits each, with a cursor. Executes insert, delete and move-cursor commands.
- Tracks the active output device, which advances each time a CEO symbol crosses the cursor.
- Raises a redraw request to the LCD display block after every change, and holds off new commands until the display acknowledges.

Parameters:
- SYM_W, 4: symbol width in bits.
- DEPTH, 64: buffer capacity in symbols. Must be 2 or more.
- NUM_DEV, 2: number of output devices. Must be 1 or more.
- CEO, 4'b1001: symbol code that changes the output device. Width SYM_W.

Ports:
- working_clock  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  a command is presented this cycle.
- cmd_op  input  2  00 = insert, 01 = delete, 10 = move, 11 = reserved (no-op; still consumes a handshake).
- cmd_dir  input  1  move direction: 1 = right, 0 = left.
- cmd_sym  input  SYM_W  symbol to insert.
- available  output  1  ready to accept a command.
- redraw_req  output  1  display-refresh request; level signal.
- redraw_ack  input  1  display has finished the refresh.
- sym_left  output  SYM_W  symbol just before the cursor; 0 when cursor = 0.
- sym_right  output  SYM_W  symbol at the cursor; 0 when cursor = length.
- length  output  $clog2(DEPTH+1)  number of stored symbols.
- cursor  output  $clog2(DEPTH+1)  cursor position, 0..length.
- output_device  output  $clog2(NUM_DEV) (minimum 1)  active device index.
- full  output  1  length == DEPTH.
- cmd_err  output  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset:
  - All buffer entries are 0; length = 0, cursor = 0, output_device = 0.
  - redraw_req = 0, cmd_err = 0, available = 1.
  - A reset asserted mid-handshake abandons the pending redraw.
- State machine has two states: IDLE and WAIT_DISP.
  - IDLE: available = 1. A command is accepted in any cycle where cmd_valid = 1.
  - Accepted command that changes state: the update completes in the same edge. Next state is WAIT_DISP with redraw_req = 1 and available = 0.
  - Accepted command that is rejected or reserved: cmd_err pulses for 1 cycle (reserved op: no pulse). State stays IDLE and no redraw is requested.
  - WAIT_DISP: cmd_valid is ignored. If redraw_ack = 1, redraw_req drops and the state returns to IDLE on the next edge. redraw_ack in IDLE is ignored.
- Insert:
  - Entries [cursor..length-1] shift up by one; cmd_sym is written at index cursor.
  - length increments and cursor increments.
  - Rejected if full = 1.
- Delete:
  - Removes the entry at cursor-1; entries [cursor..length-1] shift down by one.
  - The vacated top entry is cleared to 0. length decrements and cursor decrements.
  - Rejected if cursor = 0.
- Move right: cursor increments; rejected if cursor = length. Move left: cursor decrements; rejected if cursor = 0.
- Device tracking, applied only on successful commands, advances output_device by 1 when:
  - an insert has cmd_sym == CEO;
  - a delete removes a symbol == CEO;
  - a move right passes over sym_right == CEO;
  - a move left passes over sym_left == CEO.
- The device advance wraps modulo NUM_DEV: NUM_DEV-1 goes to 0. With NUM_DEV = 1, output_device stays at 0.
- Outputs:
  - sym_left, sym_right, length, cursor and full are registered-state derived (combinational reads of state registers).
  - They are valid the cycle after the accepting edge.
- Latency: command accepted to updated outputs is 1 cycle. The minimum interval between accepted state-changing commands is 2 cycles (ack returned immediately).

Optional Feature:
- Macro: CONSOLE_READBACK_EN.
- Defined:
  - Adds input rd_addr [$clog2(DEPTH)-1:0] and output rd_data [SYM_W-1:0].
  - rd_data is the entry at rd_addr, registered with 1-cycle latency. It reads 0 when rd_addr >= length.
  - The LCD uses this port to redraw the full program.
- Not defined: both ports are absent, and no read mux or register is built.

Test Plan:
- Insert after reset: reset 2 cycles, insert 3, insert 5 with ack returned 1 cycle after each req → length = 2, cursor = 2, sym_left = 5, sym_right = 0, output_device = 0.
- Edit in the middle: buffer [3,5] with cursor 2; move left, insert 7, delete → after the insert the buffer is [3,7,5] with cursor 2; after the delete it is [3,5] with cursor 1 and sym_right = 5.
- CEO crossing with NUM_DEV = 2: insert CEO gives output_device = 1; move left gives 0; move right gives 1; delete gives 0. Each is one redraw handshake.
- Rejections: delete at cursor 0 → cmd_err pulses 1 cycle, redraw_req stays 0, available stays 1. Fill to DEPTH = 4 and insert once more → cmd_err, length stays 4, full = 1.
- Handshake hold-off: accept an insert, hold cmd_valid = 1 with a new insert, and delay redraw_ack for 5 cycles → no second insert until the cycle after ack; available = 0 throughout the wait.
- Reset in WAIT_DISP, plus readback: reset while redraw_req = 1 → next cycle redraw_req = 0, length = 0, available = 1. With CONSOLE_READBACK_EN defined, buffer [3,5], rd_addr = 1 → rd_data = 5 one cycle later; rd_addr = 2 → 0.

Source files
------------

// File: rtl/console_edit_buffer.sv
// console_edit_buffer
//   Program-text buffer and cursor controller for the brainfuck console.
//   Holds up to DEPTH symbols with a cursor and executes insert, delete and
//   move commands. It also tracks which output device is active: every time
//   a CEO symbol crosses the cursor, the device index advances. Each change
//   raises redraw_req and blocks new commands until the LCD returns
//   redraw_ack.
//
//   Optional build macro: CONSOLE_READBACK_EN
//     Adds a registered random-access read port (rd_addr / rd_data) so the
//     LCD can redraw the whole program.
//
// Ports
//   working_clock  in   single clock, rising edge
//   reset          in   synchronous active-high reset
//   cmd_valid      in   command present this cycle
//   cmd_op         in   00 insert, 01 delete, 10 move, 11 reserved no-op
//   cmd_dir        in   move direction, 1 = right, 0 = left
//   cmd_sym        in   symbol to insert
//   available      out  ready to accept a command
//   redraw_req     out  display refresh request (level)
//   redraw_ack     in   display refresh finished
//   sym_left       out  symbol before the cursor (0 at cursor 0)
//   sym_right      out  symbol at the cursor (0 at cursor == length)
//   length         out  number of stored symbols
//   cursor         out  cursor position 0..length
//   output_device  out  active output device index
//   full           out  length == DEPTH
//   rd_addr        in   readback address (CONSOLE_READBACK_EN only)
//   rd_data        out  readback data, 1-cycle latency (CONSOLE_READBACK_EN only)
//   cmd_err        out  one-cycle pulse on a rejected command
module console_edit_buffer #(
    parameter int               SYM_W   = 4,
    parameter int               DEPTH   = 64,
    parameter int               NUM_DEV = 2,
    parameter logic [SYM_W-1:0] CEO     = 4'b1001,
    localparam int              LW      = $clog2(DEPTH + 1),
    localparam int              IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int              DW      = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1
) (
    input  logic             working_clock,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_dir,
    input  logic [SYM_W-1:0] cmd_sym,
    output logic             available,
    output logic             redraw_req,
    input  logic             redraw_ack,
    output logic [SYM_W-1:0] sym_left,
    output logic [SYM_W-1:0] sym_right,
    output logic [LW-1:0]    length,
    output logic [LW-1:0]    cursor,
    output logic [DW-1:0]    output_device,
    output logic             full,
`ifdef CONSOLE_READBACK_EN
    input  logic [IW-1:0]    rd_addr,
    output logic [SYM_W-1:0] rd_data,
`endif
    output logic             cmd_err
);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_DISP = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [SYM_W-1:0] mem_r [DEPTH];
    logic [LW-1:0]    len_r;
    logic [LW-1:0]    cur_r;
    logic [DW-1:0]    dev_r;
    logic [DW-1:0]    dev_nxt_s;
    logic             cmd_err_r;

    logic             do_ins_s;
    logic             do_del_s;
    logic             do_mvr_s;
    logic             do_mvl_s;
    logic             reject_s;
    logic             adv_s;
    logic             full_s;
    logic [IW-1:0]    left_idx_s;
    logic [IW-1:0]    right_idx_s;
    logic [IW-1:0]    top_idx_s;
    logic [SYM_W-1:0] sym_left_s;
    logic [SYM_W-1:0] sym_right_s;

    // When the cursor sits at an end, the index it produces may fall outside
    // the live data. The zero masks on sym_left_s / sym_right_s hide that case.
    assign left_idx_s  = IW'(cur_r - LW'(1));
    assign right_idx_s = IW'(cur_r);
    assign top_idx_s   = IW'(len_r - LW'(1));
    assign sym_left_s  = (cur_r == {LW{1'b0}}) ? {SYM_W{1'b0}} : mem_r[left_idx_s];
    assign sym_right_s = (cur_r == len_r)      ? {SYM_W{1'b0}} : mem_r[right_idx_s];
    assign full_s      = (len_r == LW'(DEPTH));
    assign dev_nxt_s   = (dev_r == DW'(NUM_DEV - 1)) ? {DW{1'b0}} : (dev_r + DW'(1));

    assign available     = (state_r == IDLE);
    assign redraw_req    = (state_r == WAIT_DISP);
    assign sym_left      = sym_left_s;
    assign sym_right     = sym_right_s;
    assign length        = len_r;
    assign cursor        = cur_r;
    assign output_device = dev_r;
    assign full          = full_s;
    assign cmd_err       = cmd_err_r;

    // Command decode, legality checks, device-advance decision and next state
    always_comb begin
        state_nxt_s = state_r;
        do_ins_s    = 1'b0;
        do_del_s    = 1'b0;
        do_mvr_s    = 1'b0;
        do_mvl_s    = 1'b0;
        reject_s    = 1'b0;
        adv_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        2'b00: begin
                            if (full_s) begin
                                reject_s = 1'b1;
                            end else begin
                                do_ins_s = 1'b1;
                                adv_s    = (cmd_sym == CEO);
                            end
                        end
                        2'b01: begin
                            if (cur_r == {LW{1'b0}}) begin
                                reject_s = 1'b1;
                            end else begin
                                do_del_s = 1'b1;
                                adv_s    = (sym_left_s == CEO);
                            end
                        end
                        2'b10: begin
                            if (cmd_dir) begin
                                if (cur_r == len_r) begin
                                    reject_s = 1'b1;
                                end else begin
                                    do_mvr_s = 1'b1;
                                    adv_s    = (sym_right_s == CEO);
                                end
                            end else begin
                                if (cur_r == {LW{1'b0}}) begin
                                    reject_s = 1'b1;
                                end else begin
                                    do_mvl_s = 1'b1;
                                    adv_s    = (sym_left_s == CEO);
                                end
                            end
                        end
                        default: begin
                            // reserved op: handshake consumed, nothing changes
                            reject_s = 1'b0;
                        end
                    endcase
                    if (do_ins_s || do_del_s || do_mvr_s || do_mvl_s) begin
                        state_nxt_s = WAIT_DISP;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_DISP: begin
                if (redraw_ack) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_DISP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge working_clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Buffer contents, length, cursor, device index and error pulse
    always_ff @(posedge working_clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {SYM_W{1'b0}};
            end
            len_r     <= {LW{1'b0}};
            cur_r     <= {LW{1'b0}};
            dev_r     <= {DW{1'b0}};
            cmd_err_r <= 1'b0;
        end else begin
            cmd_err_r <= reject_s;
            if (adv_s) begin
                dev_r <= dev_nxt_s;
            end
            if (do_ins_s) begin
                // open a gap at the cursor by shifting [cursor..length-1] up
                for (int i = 1; i < DEPTH; i++) begin
                    if ((LW'(i) > cur_r) && (LW'(i) <= len_r)) begin
                        mem_r[i] <= mem_r[i-1];
                    end
                end
                mem_r[right_idx_s] <= cmd_sym;
                len_r <= len_r + LW'(1);
                cur_r <= cur_r + LW'(1);
            end else if (do_del_s) begin
                // close the gap at cursor-1 by shifting [cursor..length-1] down
                for (int i = 0; i < DEPTH - 1; i++) begin
                    if ((LW'(i + 1) >= cur_r) && (LW'(i + 1) < len_r)) begin
                        mem_r[i] <= mem_r[i+1];
                    end
                end
                mem_r[top_idx_s] <= {SYM_W{1'b0}};
                len_r <= len_r - LW'(1);
                cur_r <= cur_r - LW'(1);
            end else if (do_mvr_s) begin
                cur_r <= cur_r + LW'(1);
            end else if (do_mvl_s) begin
                cur_r <= cur_r - LW'(1);
            end
        end
    end

`ifdef CONSOLE_READBACK_EN
    logic [SYM_W-1:0] rd_data_r;

    // Registered readback; addresses beyond the live text read as zero
    always_ff @(posedge working_clock) begin
        if (reset) begin
            rd_data_r <= {SYM_W{1'b0}};
        end else if (LW'(rd_addr) < len_r) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= {SYM_W{1'b0}};
        end
    end

    assign rd_data = rd_data_r;
`endif

endmodule

// File: tb/tb_console_edit_buffer.sv
// Self-checking bench for console_edit_buffer (DEPTH = 4, NUM_DEV = 2).
// The stimulus pushes the hand-computed response expected from each command
// into a queue. A monitor pops an entry and compares it whenever the DUT
// responds, which happens on the rising edge of redraw_req or on a cmd_err
// pulse.
module tb_console_edit_buffer;

    localparam int SYM_W   = 4;
    localparam int DEPTH   = 4;
    localparam int NUM_DEV = 2;

    typedef struct packed {
        logic       is_redraw;
        logic [2:0] len;
        logic [2:0] cur;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       dev;
        logic       full;
    } exp_t;

    logic       working_clock = 1'b0;
    logic       reset         = 1'b1;
    logic       cmd_valid     = 1'b0;
    logic [1:0] cmd_op        = 2'b00;
    logic       cmd_dir       = 1'b0;
    logic [3:0] cmd_sym       = 4'h0;
    logic       redraw_ack    = 1'b0;
    logic       available;
    logic       redraw_req;
    logic [3:0] sym_left;
    logic [3:0] sym_right;
    logic [2:0] length;
    logic [2:0] cursor;
    logic [0:0] output_device;
    logic       full;
    logic       cmd_err;
`ifdef CONSOLE_READBACK_EN
    logic [1:0] rd_addr = 2'd0;
    logic [3:0] rd_data;
`endif

    exp_t exp_q[$];
    exp_t mon_act;
    logic prev_req = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    console_edit_buffer #(
        .SYM_W(SYM_W), .DEPTH(DEPTH), .NUM_DEV(NUM_DEV), .CEO(4'b1001)
    ) dut (
        .working_clock(working_clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_sym(cmd_sym),
        .available(available), .redraw_req(redraw_req), .redraw_ack(redraw_ack),
        .sym_left(sym_left), .sym_right(sym_right), .length(length), .cursor(cursor),
        .output_device(output_device), .full(full),
`ifdef CONSOLE_READBACK_EN
        .rd_addr(rd_addr), .rd_data(rd_data),
`endif
        .cmd_err(cmd_err)
    );

    always #5 working_clock = ~working_clock;

    assign mon_act = {redraw_req, length, cursor, sym_left, sym_right, output_device, full};

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every DUT response is matched against the oldest expectation
    always @(negedge working_clock) begin
        if (!reset && (cmd_err || (redraw_req && !prev_req))) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_response: got req=%0b len=%0d cur=%0d, expected no response",
                         redraw_req, length, cursor);
            end else begin
                if (mon_act !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL response: got req=%0b len=%0d cur=%0d sl=%0d sr=%0d dev=%0d full=%0b, expected req=%0b len=%0d cur=%0d sl=%0d sr=%0d dev=%0d full=%0b",
                             mon_act.is_redraw, mon_act.len, mon_act.cur, mon_act.sl, mon_act.sr, mon_act.dev, mon_act.full,
                             exp_q[0].is_redraw, exp_q[0].len, exp_q[0].cur, exp_q[0].sl, exp_q[0].sr, exp_q[0].dev, exp_q[0].full);
                end
                exp_q.delete(0);
            end
        end
        prev_req <= redraw_req;
    end

    task automatic tick;
        @(posedge working_clock);
        #1;
    endtask

    task automatic wait_avail;
        int n = 0;
        while (available !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        if (available !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_available: got available=%0b after %0d cycles, expected 1", available, n);
        end
    endtask

    function automatic exp_t mk(input logic r, input int len, input int cur, input int sl,
                                input int sr, input int dev, input logic fl);
        exp_t e;
        e.is_redraw = r;
        e.len  = 3'(len);
        e.cur  = 3'(cur);
        e.sl   = 4'(sl);
        e.sr   = 4'(sr);
        e.dev  = 1'(dev);
        e.full = fl;
        return e;
    endfunction

    // kind: 1 = state change with redraw, 0 = rejected, 2 = reserved no-op
    task automatic send(input string name, input logic [1:0] op, input logic dir, input logic [3:0] sym,
                        input int kind, input int len, input int cur, input int sl, input int sr,
                        input int dev, input logic fl);
        wait_avail;
        if (kind != 2) exp_q.push_back(mk(kind == 1, len, cur, sl, sr, dev, fl));
        cmd_op    = op;
        cmd_dir   = dir;
        cmd_sym   = sym;
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        case (kind)
            1: begin
                check({name, "_redraw_req"}, redraw_req, 1);
                check({name, "_available"}, available, 0);
                redraw_ack = 1'b1;
                tick;
                redraw_ack = 1'b0;
            end
            0: begin
                check({name, "_cmd_err"}, cmd_err, 1);
                check({name, "_no_redraw"}, redraw_req, 0);
                check({name, "_available"}, available, 1);
                tick;
                check({name, "_err_pulse_end"}, cmd_err, 0);
            end
            default: begin
                check({name, "_no_err"}, cmd_err, 0);
                check({name, "_no_redraw"}, redraw_req, 0);
            end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        check("rst_length", length, 0);
        check("rst_cursor", cursor, 0);
        check("rst_device", output_device, 0);
        check("rst_redraw_req", redraw_req, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_available", available, 1);
        check("rst_full", full, 0);

        // insert after reset
        send("ins3", 2'b00, 1'b0, 4'd3, 1, 1, 1, 3, 0, 0, 1'b0);
        send("ins5", 2'b00, 1'b0, 4'd5, 1, 2, 2, 5, 0, 0, 1'b0);
        // edit in the middle
        send("mvl",  2'b10, 1'b0, 4'd0, 1, 2, 1, 3, 5, 0, 1'b0);
        send("ins7", 2'b00, 1'b0, 4'd7, 1, 3, 2, 7, 5, 0, 1'b0);
        send("del7", 2'b01, 1'b0, 4'd0, 1, 2, 1, 3, 5, 0, 1'b0);
`ifdef CONSOLE_READBACK_EN
        rd_addr = 2'd1;
        tick;
        check("rd_addr1", rd_data, 5);
        rd_addr = 2'd2;
        tick;
        check("rd_addr2_beyond_len", rd_data, 0);
        rd_addr = 2'd0;
        tick;
        check("rd_addr0", rd_data, 3);
`endif
        // CEO crossings
        send("ins_ceo", 2'b00, 1'b0, 4'd9, 1, 3, 2, 9, 5, 1, 1'b0);
        send("mvl_ceo", 2'b10, 1'b0, 4'd0, 1, 3, 1, 3, 9, 0, 1'b0);
        send("mvr_ceo", 2'b10, 1'b1, 4'd0, 1, 3, 2, 9, 5, 1, 1'b0);
        send("del_ceo", 2'b01, 1'b0, 4'd0, 1, 2, 1, 3, 5, 0, 1'b0);
        // rejections at cursor 0
        send("mvl_to0", 2'b10, 1'b0, 4'd0, 1, 2, 0, 0, 3, 0, 1'b0);
        send("del_at0", 2'b01, 1'b0, 4'd0, 0, 2, 0, 0, 3, 0, 1'b0);
        send("mvl_at0", 2'b10, 1'b0, 4'd0, 0, 2, 0, 0, 3, 0, 1'b0);
        send("reserved", 2'b11, 1'b0, 4'd0, 2, 0, 0, 0, 0, 0, 1'b0);
        // fill and overflow
        send("ins1", 2'b00, 1'b0, 4'd1, 1, 3, 1, 1, 3, 0, 1'b0);
        send("ins2", 2'b00, 1'b0, 4'd2, 1, 4, 2, 2, 3, 0, 1'b1);
        send("ins_full", 2'b00, 1'b0, 4'd4, 0, 4, 2, 2, 3, 0, 1'b1);
        send("mvr_a", 2'b10, 1'b1, 4'd0, 1, 4, 3, 3, 5, 0, 1'b1);
        send("mvr_b", 2'b10, 1'b1, 4'd0, 1, 4, 4, 5, 0, 0, 1'b1);
        send("mvr_end", 2'b10, 1'b1, 4'd0, 0, 4, 4, 5, 0, 0, 1'b1);
        send("del_top", 2'b01, 1'b0, 4'd0, 1, 3, 3, 3, 0, 0, 1'b0);
        send("del_2", 2'b01, 1'b0, 4'd0, 1, 2, 2, 2, 0, 0, 1'b0);

        // handshake hold-off with cmd_valid held high
        wait_avail;
        exp_q.push_back(mk(1'b1, 3, 3, 6, 0, 0, 1'b0));
        cmd_op    = 2'b00;
        cmd_sym   = 4'd6;
        cmd_valid = 1'b1;
        tick;
        cmd_sym = 4'd8;
        exp_q.push_back(mk(1'b1, 4, 4, 8, 0, 0, 1'b1));
        for (int k = 0; k < 5; k++) begin
            check("holdoff_available", available, 0);
            check("holdoff_length", length, 3);
            tick;
        end
        redraw_ack = 1'b1;
        tick;
        redraw_ack = 1'b0;
        check("holdoff_len_after_ack", length, 3);
        check("holdoff_avail_after_ack", available, 1);
        tick;
        cmd_valid = 1'b0;
        check("holdoff_second_insert", length, 4);
        redraw_ack = 1'b1;
        tick;
        redraw_ack = 1'b0;

        // reset while waiting for the display
        wait_avail;
        exp_q.push_back(mk(1'b1, 4, 3, 6, 8, 0, 1'b1));
        cmd_op    = 2'b10;
        cmd_dir   = 1'b0;
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        @(negedge working_clock);
        #1;
        check("pre_reset_redraw_req", redraw_req, 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("midrst_redraw_req", redraw_req, 0);
        check("midrst_length", length, 0);
        check("midrst_cursor", cursor, 0);
        check("midrst_available", available, 1);
        check("midrst_device", output_device, 0);
        check("midrst_full", full, 0);
        check("midrst_sym_right", sym_right, 0);

        send("post_rst_ceo", 2'b00, 1'b0, 4'd9, 1, 1, 1, 9, 0, 1, 1'b0);

        tick;
        tick;
        check("pending_expectations", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
